// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle for the two requesters plus the shared single-port RAM
// and the debug contention counter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              io_req;
  logic              io_we;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_gnt;
  logic              io_rvalid;
  logic [DATA_W-1:0] io_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [CNT_W-1:0]  conflict_cnt;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  io_req, io_we, io_addr, io_wdata,
    output io_gnt, io_rvalid, io_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output conflict_cnt
  );

  // Requester / RAM / debug side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output io_req, io_we, io_addr, io_wdata,
    input  io_gnt, io_rvalid, io_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  conflict_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one single-port sync RAM: grant one cycle after request,
// read data two cycles after request; requesters hold req until their gnt pulse.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter bit RR_EN  = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nxt;
  logic              owner, last_owner;  // 0 = CPU, 1 = IO
  logic              winner, grant_now, cnt_inc;
  logic              rv_pend, rv_owner;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] cpu_rd_q, io_rd_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    winner    = 1'b0;
    grant_now = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req && bus.io_req) begin
          winner  = RR_EN ? ~last_owner : 1'b0;
          cnt_inc = 1'b1;
        end else begin
          winner  = bus.io_req;
        end
        if (bus.cpu_req || bus.io_req) begin
          grant_now = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = IDLE;
        cnt_inc   = owner ? bus.cpu_req : bus.io_req;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rv_pend     <= 1'b0;
      rv_owner    <= 1'b0;
      cpu_rd_q    <= '0;
      io_rd_q     <= '0;
      cnt_q       <= '0;
    end else begin
      if (grant_now) begin
        owner       <= winner;
        last_owner  <= winner;
        mem_en_q    <= 1'b1;
        mem_we_q    <= winner ? bus.io_we    : bus.cpu_we;
        mem_addr_q  <= winner ? bus.io_addr  : bus.cpu_addr;
        mem_wdata_q <= winner ? bus.io_wdata : bus.cpu_wdata;
      end else begin
        mem_en_q    <= 1'b0;
        mem_we_q    <= 1'b0;
      end
      // RAM output appears the cycle after an enabled read; hold it per requester.
      rv_pend  <= (state == ACCESS) && !mem_we_q;
      rv_owner <= owner;
      if (rv_pend) begin
        if (rv_owner) io_rd_q  <= bus.mem_rdata;
        else          cpu_rd_q <= bus.mem_rdata;
      end
      if (cnt_inc && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.cpu_gnt      = (state == ACCESS) && !owner;
  assign bus.io_gnt       = (state == ACCESS) &&  owner;
  assign bus.cpu_rvalid   = rv_pend && !rv_owner;
  assign bus.io_rvalid    = rv_pend &&  rv_owner;
  assign bus.cpu_rdata    = bus.cpu_rvalid ? bus.mem_rdata : cpu_rd_q;
  assign bus.io_rdata     = bus.io_rvalid  ? bus.mem_rdata : io_rd_q;
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: round-robin instance against a transaction-level model
// with a golden memory, plus a fixed-priority 4-bit-counter instance for saturation.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16), .CNT_W(8)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16), .CNT_W(4)) bus_b ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RR_EN(1'b1), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a));
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RR_EN(1'b0), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b));

  // RAM behind instance A; instance B only reads and sees zeros.
  logic [15:0] ram_a [256];
  logic [15:0] ram_q_a;
  always @(posedge clock) begin
    if (bus_a.mem_en) begin
      if (bus_a.mem_we) ram_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
      else              ram_q_a <= ram_a[bus_a.mem_addr[7:0]];
    end
  end
  assign bus_a.mem_rdata = ram_q_a;
  assign bus_b.mem_rdata = 16'h0000;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: which access is in flight, who gets served next, what data is owed.
  localparam int CMAX_A = 255;
  logic [15:0] golden [256];
  logic        m_busy, m_own, m_last, m_we;
  logic [15:0] m_addr, m_wd, m_txn_rd;
  logic        m_rv, m_rv_own;
  logic [15:0] m_rv_dat, m_cpu_rd, m_io_rd;
  int          m_cnt;
  logic        prev_cgnt, prev_ignt;

  task automatic model_reset();
    m_busy = 1'b0; m_own = 1'b0; m_last = 1'b1; m_we = 1'b0;
    m_addr = 16'h0; m_wd = 16'h0; m_txn_rd = 16'h0;
    m_rv = 1'b0; m_rv_own = 1'b0; m_rv_dat = 16'h0;
    m_cpu_rd = 16'h0; m_io_rd = 16'h0; m_cnt = 0;
    prev_cgnt = 1'b0; prev_ignt = 1'b0;
  endtask

  task automatic model_check();
    logic e_cg, e_ig;
    e_cg = m_busy && !m_own;
    e_ig = m_busy &&  m_own;
    chk("cpu_gnt", bus_a.cpu_gnt, e_cg);
    chk("io_gnt",  bus_a.io_gnt,  e_ig);
    chk("mem_en",  bus_a.mem_en,  m_busy);
    chk("mem_we",  bus_a.mem_we,  m_busy && m_we);
    if (m_busy) chk("mem_addr", bus_a.mem_addr, m_addr);
    if (m_busy && m_we) chk("mem_wdata", bus_a.mem_wdata, m_wd);
    chk("cpu_rvalid", bus_a.cpu_rvalid, m_rv && !m_rv_own);
    chk("io_rvalid",  bus_a.io_rvalid,  m_rv &&  m_rv_own);
    chk("cpu_rdata", bus_a.cpu_rdata, (m_rv && !m_rv_own) ? m_rv_dat : m_cpu_rd);
    chk("io_rdata",  bus_a.io_rdata,  (m_rv &&  m_rv_own) ? m_rv_dat : m_io_rd);
    chk("conflict_cnt", bus_a.conflict_cnt, m_cnt);
    prev_cgnt = e_cg;
    prev_ignt = e_ig;
  endtask

  task automatic model_advance(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                               input logic ir, input logic iw, input logic [15:0] ia, input logic [15:0] id);
    logic w;
    if (m_busy ? (m_own ? cr : ir) : (cr && ir))
      if (m_cnt < CMAX_A) m_cnt++;
    if (m_rv) begin
      if (m_rv_own) m_io_rd = m_rv_dat;
      else          m_cpu_rd = m_rv_dat;
    end
    m_rv     = m_busy && !m_we;
    m_rv_own = m_own;
    m_rv_dat = m_txn_rd;
    if (m_busy) begin
      m_busy = 1'b0;
    end else if (cr || ir) begin
      w      = (cr && ir) ? !m_last : ir;
      m_own  = w;
      m_last = w;
      m_we   = w ? iw : cw;
      m_addr = w ? ia : ca;
      m_wd   = w ? id : cd;
      if (m_we) golden[m_addr[7:0]] = m_wd;
      else      m_txn_rd = golden[m_addr[7:0]];
      m_busy = 1'b1;
    end
  endtask

  // One cycle of instance A: drive, check this cycle's outputs, advance the model.
  task automatic step(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                      input logic ir, input logic iw, input logic [15:0] ia, input logic [15:0] id);
    bus_a.cpu_req = cr; bus_a.cpu_we = cw; bus_a.cpu_addr = ca; bus_a.cpu_wdata = cd;
    bus_a.io_req  = ir; bus_a.io_we  = iw; bus_a.io_addr  = ia; bus_a.io_wdata  = id;
    #1;
    model_check();
    model_advance(cr, cw, ca, cd, ir, iw, ia, id);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_a();
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus_a.cpu_req = 1'b0; bus_a.io_req = 1'b0;
    bus_a.cpu_we = 1'b0;  bus_a.io_we = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 16'h1111) ^ 16'h5A5A;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        c_req, c_we, i_req, i_we;
    logic [15:0] c_addr, c_wd, i_addr, i_wd;

    for (int i = 0; i < 256; i++) golden[i] = 16'h0;
    bus_a.cpu_addr = 16'h0; bus_a.cpu_wdata = 16'h0; bus_a.io_addr = 16'h0; bus_a.io_wdata = 16'h0;
    bus_b.cpu_req = 1'b0; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = 16'h0; bus_b.cpu_wdata = 16'h0;
    bus_b.io_req  = 1'b0; bus_b.io_we  = 1'b0; bus_b.io_addr  = 16'h0; bus_b.io_wdata  = 16'h0;

    // Reset values.
    do_reset();
    chk("rst_cpu_gnt", bus_a.cpu_gnt, 0);
    chk("rst_io_gnt", bus_a.io_gnt, 0);
    chk("rst_rvalid", {bus_a.cpu_rvalid, bus_a.io_rvalid}, 0);
    chk("rst_mem_en_we", {bus_a.mem_en, bus_a.mem_we}, 0);
    chk("rst_mem_addr", bus_a.mem_addr, 0);
    chk("rst_mem_wdata", bus_a.mem_wdata, 0);
    chk("rst_cnt", bus_a.conflict_cnt, 0);
    chk("rst_rdata", {bus_a.cpu_rdata, bus_a.io_rdata}, 0);

    // Preload addresses 0..15 via CPU writes, then 0xBEEF at 0x0010 via IO.
    for (int a = 0; a < 16; a++) begin
      step(1'b1, 1'b1, 16'(a), init_val(a), 1'b0, 1'b0, 16'h0, 16'h0);
      step(1'b1, 1'b1, 16'(a), init_val(a), 1'b0, 1'b0, 16'h0, 16'h0);
    end
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    idle_a();

    // CPU read only.
    do_reset();
    step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rd_cpu_gnt", bus_a.cpu_gnt, 1);
    chk("rd_mem_en", bus_a.mem_en, 1);
    chk("rd_mem_addr", bus_a.mem_addr, 16'h0010);
    chk("rd_io_gnt", bus_a.io_gnt, 0);
    step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rd_cpu_rvalid", bus_a.cpu_rvalid, 1);
    chk("rd_cpu_rdata", bus_a.cpu_rdata, 16'hBEEF);
    chk("rd_io_outs", {bus_a.io_gnt, bus_a.io_rvalid, bus_a.io_rdata}, 0);
    idle_a();
    idle_a();

    // Both held, round-robin: CPU, IO, CPU, IO on cycles 1, 3, 5, 7.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_cpu_gnt", bus_a.cpu_gnt, (k % 4) == 1);
      chk("rr_io_gnt", bus_a.io_gnt, (k % 4) == 3);
      chk("rr_cnt", bus_a.conflict_cnt, k);
      step(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
    end
    idle_a();

    // IO write then CPU read of the same address.
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h1234);
    chk("wr_io_gnt", bus_a.io_gnt, 1);
    chk("wr_mem_we", bus_a.mem_we, 1);
    chk("wr_mem_wdata", bus_a.mem_wdata, 16'h1234);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h1234);
    chk("wr_mem_we_after", bus_a.mem_we, 0);
    chk("wr_no_io_rvalid", bus_a.io_rvalid, 0);
    step(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("wr_cpu_rvalid", bus_a.cpu_rvalid, 1);
    chk("wr_cpu_rdata", bus_a.cpu_rdata, 16'h1234);
    idle_a();

    // Reset during a read access.
    step(1'b1, 1'b0, 16'h0005, 16'h0, 1'b1, 1'b0, 16'h0006, 16'h0);
    chk("mr_gnt_before", bus_a.cpu_gnt | bus_a.io_gnt, 1);
    #1 reset = 1'b0;
    #1;
    chk("mr_gnt_drop", {bus_a.cpu_gnt, bus_a.io_gnt}, 0);
    chk("mr_mem_drop", {bus_a.mem_en, bus_a.mem_we}, 0);
    bus_a.cpu_req = 1'b0; bus_a.io_req = 1'b0;
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    idle_a();
    idle_a();
    chk("mr_no_rvalid", {bus_a.cpu_rvalid, bus_a.io_rvalid}, 0);
    chk("mr_cnt", bus_a.conflict_cnt, 0);
    step(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("mr_next_gnt", bus_a.cpu_gnt, 1);
    step(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("mr_next_rdata", bus_a.cpu_rdata, init_val(3));
    idle_a();

    // Random traffic: each requester holds its access until granted.
    c_req = 1'b0; c_we = 1'b0; c_addr = 16'h0; c_wd = 16'h0;
    i_req = 1'b0; i_we = 1'b0; i_addr = 16'h0; i_wd = 16'h0;
    for (int n = 0; n < 600; n++) begin
      if (!c_req || prev_cgnt) begin
        c_req  = ($urandom_range(0, 3) != 0);
        c_we   = 1'($urandom_range(0, 1));
        c_addr = 16'($urandom_range(0, 15));
        c_wd   = 16'($urandom);
      end
      if (!i_req || prev_ignt) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_we   = 1'($urandom_range(0, 1));
        i_addr = 16'($urandom_range(0, 15));
        i_wd   = 16'($urandom);
      end
      step(c_req, c_we, c_addr, c_wd, i_req, i_we, i_addr, i_wd);
    end
    idle_a();

    // Fixed priority with a 4-bit counter: CPU always wins, counter saturates.
    do_reset();
    bus_b.cpu_req = 1'b1; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = 16'h0001;
    bus_b.io_req  = 1'b1; bus_b.io_we  = 1'b0; bus_b.io_addr  = 16'h0002;
    for (int k = 0; k < 40; k++) begin
      #1;
      chk("fp_cpu_gnt", bus_b.cpu_gnt, (k % 2) == 1);
      chk("fp_io_gnt", bus_b.io_gnt, 0);
      if ((k % 2) == 1) chk("fp_mem_addr", bus_b.mem_addr, 16'h0001);
      chk("sat_cnt", bus_b.conflict_cnt, (k < 15) ? k : 15);
      @(posedge clock);
    end
    #1;
    chk("sat_hold", bus_b.conflict_cnt, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
